pipelined_nbit_adder: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor. Splits a WIDTH-bit operation into STAGES equal carry-chained slices, one slice per pipeline stage, so a full-width add sustains one result per cycle at any width. Sits between an upstream operand producer and a downstream consumer, with valid/ready handshakes on both sides. Adds subtract mode, carry-out, signed overflow and per-stage backpressure.

---
 rtl/pipelined_nbit_adder_pkg.sv | 16 +
 rtl/pipelined_nbit_adder_slice.sv | 28 ++
 rtl/pipelined_nbit_adder.sv | 105 ++++++++++
 tb/tb_pipelined_nbit_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_nbit_adder_pkg.sv
// Shared constants and helpers for the pipelined adder: default geometry and
// slice/stage-index width calculations.
package pipelined_nbit_adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic int stage_idx_width(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/pipelined_nbit_adder_slice.sv
// Combinational SW-bit ripple adder; also reports the carry into its MSB so the
// top slice can derive signed overflow.
module adder_slice #(
  parameter int SW = 8
) (
  input  logic [SW-1:0] a,
  input  logic [SW-1:0] b,
  input  logic          cin,
  output logic [SW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  always_comb begin
    logic c;
    // NOTE: every output gets a default first, so no path through the loop can infer a latch.
    sum  = '0;
    cmsb = cin;
    c    = cin;
    for (int i = 0; i < SW; i++) begin
      if (i == SW - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_nbit_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one carry-chained slice per stage with
// per-stage valid/ready so bubbles collapse and backpressure stalls cleanly.
module pipelined_nbit_adder
  import pipelined_nbit_adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW = slice_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_nbit_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Low bits of s are finished slices; a/b still carry the unprocessed high slices.
  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             cmsb;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t          src;
    stage_t          nxt;
    stage_t          q;
    logic            take;
    logic [SW-1:0]   slice_sum;
    logic            slice_cout;
    logic            slice_cmsb;

    if (k == 0) begin : g_src
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.a     = a;
        src.b     = sub ? ~b : b;
        src.carry = sub ? ~cin : cin;
      end
    end else begin : g_src
      assign src = g_stage[k-1].q;
    end

    // A stage may load when empty or when its current beat moves on this cycle.
    if (k == STAGES - 1) begin : g_take
      assign take = !q.valid || out_ready;
    end else begin : g_take
      assign take = !q.valid || g_stage[k+1].take;
    end

    adder_slice #(.SW(SW)) u_slice (
      .a    (src.a[k*SW +: SW]),
      .b    (src.b[k*SW +: SW]),
      .cin  (src.carry),
      .sum  (slice_sum),
      .cout (slice_cout),
      .cmsb (slice_cmsb)
    );

    always_comb begin
      nxt                = src;
      nxt.s[k*SW +: SW]  = slice_sum;
      nxt.carry          = slice_cout;
      nxt.cmsb           = slice_cmsb;
    end

    always_ff @(posedge clk) begin
      // NOTE: the datapath is reset along with valid because sum/cout/ovf must read 0 after reset.
      if (rst) begin
        q <= '0;
      end else if (take) begin
        if (src.valid) q <= nxt;
        else           q.valid <= 1'b0;
      end
    end
  end

  assign in_ready  = !rst && g_stage[0].take;
  assign out_valid = g_stage[STAGES-1].q.valid;
  assign sum       = g_stage[STAGES-1].q.s;
  assign cout      = g_stage[STAGES-1].q.carry;
  assign ovf       = g_stage[STAGES-1].q.cmsb ^ g_stage[STAGES-1].q.carry;

  // Operand bits are fully consumed by the last stage and have no further reader.
  logic operands_unused;
  assign operands_unused = ^{g_stage[STAGES-1].q.a, g_stage[STAGES-1].q.b};

endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// Bench for pipelined_nbit_adder: WIDTH=8/STAGES=2 main instance checked every
// cycle against a queue model, plus STAGES=1 and STAGES=8 latency sweeps.
module tb_pipelined_nbit_adder;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         sw_valid, sw_cin, sw_sub, sw_out_ready;
  logic [W-1:0] sw_a, sw_b;
  logic         s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
  logic [W-1:0] s1_sum;
  logic         s8_in_ready, s8_out_valid, s8_cout, s8_ovf;
  logic [W-1:0] s8_sum;

  int n_vec  = 0;
  int n_err  = 0;
  int n_emit = 0;

  always #5 clk = ~clk;

  pipelined_nbit_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_nbit_adder #(.WIDTH(W), .STAGES(1)) dut_s1 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s1_in_ready), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(s1_out_valid), .out_ready(sw_out_ready),
    .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
  );

  pipelined_nbit_adder #(.WIDTH(W), .STAGES(W)) dut_s8 (
    .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s8_in_ready), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .out_valid(s8_out_valid), .out_ready(sw_out_ready),
    .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic, returns {ovf, cout, sum}.
  function automatic logic [9:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W:0] r;
    int         sr;
    if (!s) begin
      r  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      sr = int'($signed(x)) + int'($signed(y)) + int'(c);
      return {(sr > 127 || sr < -128), r[W], r[W-1:0]};
    end else begin
      r  = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
      sr = int'($signed(x)) - int'($signed(y)) - int'(c);
      return {(sr > 127 || sr < -128), !r[W], r[W-1:0]};
    end
  endfunction

  // Compare process: in-order scoreboard, in_ready occupancy rule, hold stability.
  logic [9:0] exp_q [$];
  logic       held = 1'b0;
  logic [9:0] held_val = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'(0));
    end else begin
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < S || out_ready));
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'(1));
        check("hold_data", 32'({ovf, cout, sum}), 32'(held_val));
      end
      if (out_valid && out_ready) begin
        n_emit++;
        if (exp_q.size() == 0) check("spurious_out", 32'(out_valid), 32'(0));
        else check("result", 32'({ovf, cout, sum}), 32'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
      held     = out_valid && !out_ready;
      held_val = {ovf, cout, sum};
    end
  end

  task automatic one_beat(input string name, input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tcin, input logic tsub, input logic [9:0] exp, input int exp_lat);
    int lat;
    @(posedge clk); #1;
    a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    check({name, "_res"}, 32'({ovf, cout, sum}), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, lat, lat1, lat8;
    logic [9:0] r1, r8;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_outputs", 32'({ovf, cout, sum}), 32'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'(1));

    // Directed vectors with hand-computed results
    one_beat("add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 10'h280, 2);
    one_beat("sub_05_07", 8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE, 2);
    one_beat("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 10'h37F, 2);
    one_beat("add_ff_01_c", 8'hFF, 8'h01, 1'b1, 1'b0, 10'h101, 2);

    // Back-to-back random beats, consumer always ready
    @(posedge clk); #1;
    e0 = n_emit;
    for (int i = 0; i < 16; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      check("b2b_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (S + 2) @(posedge clk);
    #1;
    check("b2b_count", 32'(n_emit - e0), 32'(16));

    // Backpressure: two beats fill the pipe, third waits until release
    e0 = n_emit;
    out_ready = 1'b0;
    a = 8'h10; b = 8'h20; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44; cin = 1'b1; sub = 1'b1;
    @(posedge clk); #1;
    a = 8'hC0; b = 8'h50; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready_low", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (S + 3) @(posedge clk);
    #1;
    check("bp_drain_count", 32'(n_emit - e0), 32'(3));

    // Reset with two beats in flight
    e0 = n_emit;
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h03; b = 8'h04;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_outputs", 32'({ovf, cout, sum}), 32'(0));
    repeat (S + 3) @(posedge clk);
    #1;
    check("midrst_no_stale", 32'(n_emit - e0), 32'(0));

    // STAGES=1 and STAGES=WIDTH latency sweep
    check("sweep_s1_ready", 32'(s1_in_ready), 32'(1));
    check("sweep_s8_ready", 32'(s8_in_ready), 32'(1));
    sw_a = 8'hFF; sw_b = 8'h01; sw_cin = 1'b1; sw_sub = 1'b0; sw_valid = 1'b1;
    @(posedge clk); #1;
    sw_valid = 1'b0;
    lat = 1; lat1 = 0; lat8 = 0; r1 = '0; r8 = '0;
    while ((lat1 == 0 || lat8 == 0) && lat < 40) begin
      if (s1_out_valid && lat1 == 0) begin lat1 = lat; r1 = {s1_ovf, s1_cout, s1_sum}; end
      if (s8_out_valid && lat8 == 0) begin lat8 = lat; r8 = {s8_ovf, s8_cout, s8_sum}; end
      @(posedge clk); #1;
      lat++;
    end
    check("sweep_s1_lat", 32'(lat1), 32'(1));
    check("sweep_s1_res", 32'(r1), 32'(10'h101));
    check("sweep_s8_lat", 32'(lat8), 32'(8));
    check("sweep_s8_res", 32'(r8), 32'(10'h101));

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
